// File: rtl/serial_ck_pkg.sv
// rtl/serial_ck_pkg.sv - shared state encoding and input clamps for the serial clock/data transmitter
package serial_ck_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEAD = 3'd1;
    localparam logic [2:0] ST_PH1  = 3'd2;
    localparam logic [2:0] ST_PH2  = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEAD = ST_LEAD,
        PH1  = ST_PH1,
        PH2  = ST_PH2,
        TAIL = ST_TAIL
    } state_t;

    function automatic logic [7:0] clamp_nbits(input logic [7:0] n, input logic [7:0] w_max);
        if (n == 8'd0) return 8'd1;
        if (n > w_max) return w_max;
        return n;
    endfunction

    function automatic logic [31:0] clamp_len(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/serial_ck_timer.sv
// rtl/serial_ck_timer.sv - loadable phase down-counter shared by all transmitter phases
module serial_ck_timer #(
    parameter int P_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [P_CNT_W-1:0] len,
    output logic               expire
);

    logic [P_CNT_W-1:0] cnt;

    // Loaded with (length-1) so a phase lasts exactly 'length' cycles; parks at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cnt != '0) begin
            cnt <= cnt - P_CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/serial_ck_tx.sv
// rtl/serial_ck_tx.sv - multi-lane framed serial clock/data transmitter with start/busy/done handshake
module serial_ck_tx
    import serial_ck_pkg::*;
#(
    parameter int   P_NCH   = 1,
    parameter int   P_W     = 32,
    parameter int   P_CNT_W = 16,
    parameter logic P_CPOL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   lsb_first,
    input  logic [7:0]             nbits,
    input  logic [P_CNT_W-1:0]     n0,
    input  logic [P_CNT_W-1:0]     n1,
    input  logic [P_CNT_W-1:0]     n2,
    input  logic [P_NCH*P_W-1:0]   data,
    output logic                   busy,
    output logic                   done,
    output logic                   cs_n,
    output logic                   sck,
    output logic [P_NCH-1:0]       sd
);

    localparam logic [7:0] W_MAX = 8'(P_W);

    state_t                 state, state_nx;
    logic [7:0]             nbits_q, nbits_nx;
    logic [7:0]             bit_cnt, bit_cnt_nx;
    logic [P_CNT_W-1:0]     n0_q, n0_nx, n1_q, n1_nx, n2_q, n2_nx;
    logic                   lsb_q, lsb_nx;
    logic [P_NCH*P_W-1:0]   data_q, data_nx;
    logic                   busy_nx, done_nx, cs_n_nx, sck_nx;
    logic [P_NCH-1:0]       sd_nx;
    logic                   more_bits;
    logic                   tmr_load;
    logic [P_CNT_W-1:0]     tmr_len;
    logic                   tmr_expire;

    function automatic logic [P_CNT_W-1:0] len_m1(input logic [P_CNT_W-1:0] n);
        return P_CNT_W'(clamp_len(32'(n)) - 32'd1);
    endfunction

    // Bit idx of the frame for every lane; MSB-first starts at bit nb-1 of the lane field.
    function automatic logic [P_NCH-1:0] pick(input logic [P_NCH*P_W-1:0] d, input logic lsb,
                                              input logic [7:0] nb, input logic [7:0] idx);
        logic [7:0]       pos;
        logic [P_NCH-1:0] r;
        pos = lsb ? idx : (nb - 8'd1 - idx);
        for (int k = 0; k < P_NCH; k++) begin
            r[k] = d[k*P_W + int'(pos)];
        end
        return r;
    endfunction

    serial_ck_timer #(.P_CNT_W(P_CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    assign more_bits = (bit_cnt < nbits_q - 8'd1);

    always_comb begin
        state_nx   = state;
        nbits_nx   = nbits_q;
        bit_cnt_nx = bit_cnt;
        n0_nx      = n0_q;
        n1_nx      = n1_q;
        n2_nx      = n2_q;
        lsb_nx     = lsb_q;
        data_nx    = data_q;
        busy_nx    = busy;
        done_nx    = 1'b0;
        cs_n_nx    = cs_n;
        sck_nx     = sck;
        sd_nx      = sd;
        tmr_load   = 1'b0;
        tmr_len    = n0_q;

        case (state)
            IDLE: begin
                // The done cycle is still IDLE; a start seen there is deliberately dropped.
                if (start && !done) begin
                    nbits_nx   = clamp_nbits(nbits, W_MAX);
                    n0_nx      = len_m1(n0);
                    n1_nx      = len_m1(n1);
                    n2_nx      = len_m1(n2);
                    lsb_nx     = lsb_first;
                    data_nx    = data;
                    bit_cnt_nx = 8'd0;
                    sd_nx      = pick(data, lsb_first, clamp_nbits(nbits, W_MAX), 8'd0);
                    cs_n_nx    = 1'b0;
                    busy_nx    = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_len    = len_m1(n0);
                    state_nx   = LEAD;
                end
            end
            LEAD: begin
                if (tmr_expire) begin
                    sck_nx   = !P_CPOL;
                    tmr_load = 1'b1;
                    tmr_len  = n1_q;
                    state_nx = PH1;
                end
            end
            PH1: begin
                if (tmr_expire) begin
                    sck_nx   = P_CPOL;
                    if (more_bits) sd_nx = pick(data_q, lsb_q, nbits_q, bit_cnt + 8'd1);
                    tmr_load = 1'b1;
                    tmr_len  = n2_q;
                    state_nx = PH2;
                end
            end
            PH2: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (more_bits) begin
                        bit_cnt_nx = bit_cnt + 8'd1;
                        sck_nx     = !P_CPOL;
                        tmr_len    = n1_q;
                        state_nx   = PH1;
                    end else begin
                        tmr_len  = n0_q;
                        state_nx = TAIL;
                    end
                end
            end
            TAIL: begin
                if (tmr_expire) begin
                    busy_nx  = 1'b0;
                    cs_n_nx  = 1'b1;
                    sd_nx    = '0;
                    sck_nx   = P_CPOL;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort) begin
            state_nx   = IDLE;
            bit_cnt_nx = 8'd0;
            busy_nx    = 1'b0;
            done_nx    = 1'b0;
            cs_n_nx    = 1'b1;
            sck_nx     = P_CPOL;
            sd_nx      = '0;
            tmr_load   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            nbits_q <= 8'd0;
            bit_cnt <= 8'd0;
            n0_q    <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            lsb_q   <= 1'b0;
            data_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            sck     <= P_CPOL;
            sd      <= '0;
        end else begin
            state   <= state_nx;
            nbits_q <= nbits_nx;
            bit_cnt <= bit_cnt_nx;
            n0_q    <= n0_nx;
            n1_q    <= n1_nx;
            n2_q    <= n2_nx;
            lsb_q   <= lsb_nx;
            data_q  <= data_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            cs_n    <= cs_n_nx;
            sck     <= sck_nx;
            sd      <= sd_nx;
        end
    end

endmodule

// File: tb/tb_serial_ck_tx.sv
// tb/tb_serial_ck_tx.sv - directed bench for serial_ck_tx, CPOL=0 and CPOL=1 instances side by side
module tb_serial_ck_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lsb_first = 1'b0;
    logic [7:0]  nbits = 8'd8;
    logic [15:0] n0 = 16'd1, n1 = 16'd1, n2 = 16'd1;
    logic [15:0] data = 16'h0000;

    logic       busy, done, cs_n, sck;
    logic [1:0] sd;
    logic       busy1, done1, cs_n1, sck1;
    logic [1:0] sd1;

    int errors = 0;
    int checks = 0;

    logic       sck_a  [0:127];
    logic       sck1_a [0:127];
    logic [1:0] sd_a   [0:127];
    logic       done_a [0:127];
    logic       cs_a   [0:127];
    logic       busy_a [0:127];

    always #5 clk = ~clk;

    serial_ck_tx #(.P_NCH(2), .P_W(8), .P_CNT_W(16), .P_CPOL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lsb_first(lsb_first),
        .nbits(nbits), .n0(n0), .n1(n1), .n2(n2), .data(data),
        .busy(busy), .done(done), .cs_n(cs_n), .sck(sck), .sd(sd)
    );

    serial_ck_tx #(.P_NCH(2), .P_W(8), .P_CNT_W(16), .P_CPOL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lsb_first(lsb_first),
        .nbits(nbits), .n0(n0), .n1(n1), .n2(n2), .data(data),
        .busy(busy1), .done(done1), .cs_n(cs_n1), .sck(sck1), .sd(sd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index c holds outputs after edge t+c, where t is the edge that samples start.
    task automatic capture(input int ncyc, input int abort_at, input int rst_at, input bit hold);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            sck_a[c] = sck; sck1_a[c] = sck1; sd_a[c] = sd;
            done_a[c] = done; cs_a[c] = cs_n; busy_a[c] = busy;
            if (!hold) start = 1'b0;
            abort = (c + 1 == abort_at);
            rst_n = !(c + 1 == rst_at);
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic analyze(input string tag, input int a0, input int a1, input int a2, input int nb,
                           input logic [7:0] e0, input logic [7:0] e1, input int ncyc);
        int pulses, act, time_bad, inv_bad, ndone, fd, fdi;
        logic [7:0] g0, g1;
        pulses = 0; act = 0; time_bad = 0; inv_bad = 0; ndone = 0; fd = -1;
        g0 = 8'h00; g1 = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            if (sck_a[c] === 1'b1 && (c == 0 || sck_a[c-1] === 1'b0)) begin
                if (c != a0 + pulses * (a1 + a2)) time_bad++;
                g0 = {g0[6:0], sd_a[c][0]};
                g1 = {g1[6:0], sd_a[c][1]};
                pulses++;
            end
            if (sck_a[c] === 1'b1) act++;
            if (sck1_a[c] !== ~sck_a[c]) inv_bad++;
            if (done_a[c] === 1'b1) begin
                ndone++;
                if (fd < 0) fd = c;
            end
        end
        fdi = (fd > 0) ? fd : 1;
        chk({tag, ".pulses"}, pulses, nb);
        chk({tag, ".active_cycles"}, act, nb * a1);
        chk({tag, ".edge_time_errs"}, time_bad, 0);
        chk({tag, ".cpol1_mismatch"}, inv_bad, 0);
        chk({tag, ".done_at"}, fd, 2 * a0 + nb * (a1 + a2));
        chk({tag, ".done_count"}, ndone, 1);
        chk({tag, ".lane0"}, g0, e0);
        chk({tag, ".lane1"}, g1, e1);
        chk({tag, ".cs_start"}, {cs_a[0], busy_a[0]}, 2'b01);
        chk({tag, ".cs_last"}, {cs_a[fdi-1], busy_a[fdi-1]}, 2'b01);
        chk({tag, ".cs_done"}, {cs_a[fdi], busy_a[fdi], sd_a[fdi]}, 4'b1000);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", {busy, done, cs_n, sck, sd, sck1}, 7'b0010001);
        rst_n = 1'b1;
        @(negedge clk);

        n0 = 16'd2; n1 = 16'd3; n2 = 16'd3; nbits = 8'd8; data = 16'h3CA5; lsb_first = 1'b0;
        capture(60, -1, -1, 1'b0);
        analyze("msb", 2, 3, 3, 8, 8'hA5, 8'h3C, 60);

        lsb_first = 1'b1;
        capture(60, -1, -1, 1'b0);
        analyze("lsb", 2, 3, 3, 8, 8'hA5, 8'h3C, 60);

        data = 16'h3C01;
        capture(60, -1, -1, 1'b0);
        analyze("lsb01", 2, 3, 3, 8, 8'h80, 8'h3C, 60);

        n0 = 16'd0; n1 = 16'd0; n2 = 16'd0; nbits = 8'd0; data = 16'h3CA5; lsb_first = 1'b0;
        capture(10, -1, -1, 1'b0);
        analyze("min", 1, 1, 1, 1, 8'h01, 8'h00, 10);

        nbits = 8'd200;
        capture(24, -1, -1, 1'b0);
        analyze("nb200", 1, 1, 1, 8, 8'hA5, 8'h3C, 24);

        n0 = 16'd1; n1 = 16'd2; n2 = 16'd1; nbits = 8'd4;
        capture(20, -1, -1, 1'b0);
        analyze("nb4", 1, 2, 1, 4, 8'h05, 8'h0C, 20);

        n0 = 16'd2; n1 = 16'd3; n2 = 16'd3; nbits = 8'd8;
        capture(20, 10, -1, 1'b0);
        chk("abort.before", {cs_a[9], busy_a[9], sck_a[9]}, 3'b011);
        chk("abort.after", {busy_a[10], cs_a[10], sck_a[10], sd_a[10], sck1_a[10]}, 6'b010001);
        nd = 0;
        for (int c = 0; c < 20; c++) if (done_a[c] === 1'b1) nd++;
        chk("abort.no_done", nd, 0);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("abort_over_start", {busy, cs_n}, 2'b01);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        capture(30, -1, 20, 1'b0);
        chk("rst.before", {busy_a[19], cs_a[19]}, 2'b10);
        chk("rst.after", {busy_a[20], done_a[20], cs_a[20], sck_a[20], sd_a[20], sck1_a[20]}, 7'b0010001);
        capture(60, -1, -1, 1'b0);
        analyze("post_rst", 2, 3, 3, 8, 8'hA5, 8'h3C, 60);

        capture(56, -1, -1, 1'b1);
        analyze("hold", 2, 3, 3, 8, 8'hA5, 8'h3C, 56);
        chk("hold.done_cycle_start", busy_a[53], 1'b0);
        chk("hold.restart", busy_a[54], 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold.cleanup", {busy, cs_n}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_ck_tx.md
# serial_ck_tx

Parametrised multi-lane serial clock/data transmitter: on a start strobe it latches a frame and drives one framed serial clock (`sck`) plus `P_NCH` parallel data lanes (`sd`). Phase lengths are set per frame in `clk` cycles; bit order and clock polarity are selectable. It adds a start/busy/done handshake, a chip select, abort and LSB-first mode. It sits between register-mapped control logic and off-chip serial DAC/ADC/shift-register devices.

## Interface
- `P_NCH`, 1: number of data lanes sharing `sck`.
- `P_W`, 32: maximum bits per frame per lane.
- `P_CNT_W`, 16: width of phase-length inputs.
- `P_CPOL`, 0: idle level of `sck`. The active level is `!P_CPOL`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  frame request, sampled only in IDLE
- `abort`  in  1  synchronous abort, any state
- `lsb_first`  in  1  0: MSB of the lane field first; 1: LSB first
- `nbits`  in  8  bits per lane; clamped to the range 1..`P_W`
- `n0`  in  `P_CNT_W`  lead/tail length in cycles; 0 is treated as 1
- `n1`  in  `P_CNT_W`  active-level `sck` length; 0 is treated as 1
- `n2`  in  `P_CNT_W`  idle-level `sck` length; 0 is treated as 1
- `data`  in  `P_NCH*P_W`  lane k occupies `data[k*P_W +: P_W]`; only the low `nbits` bits are sent
- `busy`  out  1  high from the start edge until the done edge
- `done`  out  1  one-cycle pulse at frame completion
- `cs_n`  out  1  low while a frame is active
- `sck`  out  1  serial clock
- `sd`  out  `P_NCH`  serial data, one bit per lane

## Operation
- States: IDLE, LEAD, PH1, PH2, TAIL.
- IDLE: `sck`=`P_CPOL`, `sd`=0, `cs_n`=1, `busy`=0.
  - On `start`, latch `nbits`, `n0`, `n1`, `n2`, `lsb_first` and `data` (all clamped).
  - Drive the first bit of each lane on `sd`, set `cs_n`=0 and `busy`=1, then go to LEAD.
- LEAD: hold for n0 cycles, then set `sck`=`!P_CPOL` and go to PH1.
- PH1: hold for n1 cycles, then set `sck`=`P_CPOL` and go to PH2.
  - If bits remain, shift the next bit onto `sd` on the same edge.
  - Otherwise `sd` holds the last bit.
- Data changes only on the active-to-idle `sck` transition, so receivers sample on the idle-to-active transition.
- PH2: hold for n2 cycles.
  - If the bit counter is below `nbits`-1: increment it, set `sck` active, go to PH1.
  - Otherwise go to TAIL.
- TAIL: hold for n0 cycles, then go to IDLE with all outputs at idle values and `done`=1 for one cycle.
- Inputs are ignored outside IDLE. A `start` while busy is dropped, not queued.
- `abort` (any state, including the cycle `start` arrives): at the next edge go to IDLE with idle outputs. No `done` is issued.
- `abort` has priority over `start`.
- `start` on the same cycle that `done` pulses is ignored. A new frame needs `start` while `busy`=0.
- Arithmetic:
  - The phase timer is a `P_CNT_W`-bit down-counter loaded with (length-1); phase lengths never wrap.
  - The bit counter is 8 bits.

## Timing
- Reset (`rst_n`=0 at an edge) values: IDLE, `sck`=`P_CPOL`, `sd`=0, `cs_n`=1, `busy`=0, `done`=0, counters 0.
- Reset mid-frame behaves like `abort`.
- With `start` sampled at edge t:
  - `cs_n` falls at t.
  - First `sck` active edge at t+n0.
  - Bit i active edge at t+n0+i·(n1+n2).
  - `done` high in the cycle after edge t+2·n0+nbits·(n1+n2).
- Minimum frame (all lengths 1, `nbits`=1): `done` at t+4.
- Start latency: 0 cycles; all outputs are registered.

## Structure
- Package `serial_ck_pkg`:
  - state encoding localparams (IDLE=0, LEAD=1, PH1=2, PH2=3, TAIL=4, 3 bits)
  - the `nbits` clamp function
  - the zero-to-one length clamp function
- Sub-module `serial_ck_timer`:
  - loadable `P_CNT_W` down-counter with `load`, `len` and a `expire` output
  - one instance, shared by all phases

## Test plan
- `P_NCH`=2, `P_W`=8, `nbits`=8, n0=2, n1=3, n2=3, lane0=0xA5, lane1=0x3C, MSB first -> 8 `sck` pulses (3 active, 3 idle); `sd[0]`=1,0,1,0,0,1,0,1 and `sd[1]`=0,0,1,1,1,1,0,0; `done` at t+52.
- Same stimulus with `lsb_first`=1 -> `sd[0]`=1,0,1,0,0,1,0,1 (0xA5 is a bit-palindrome) and `sd[1]`=0,0,1,1,1,1,0,0. Then lane0=0x01 -> first bit 1, remaining seven bits 0.
- n0=n1=n2=0, `nbits`=0 -> clamped to 1/1; one `sck` pulse one cycle wide; `done` at t+4. `nbits`=200 with `P_W`=8 -> exactly 8 pulses.
- `P_CPOL`=1 -> `sck` idles high and pulses low; edge times are identical to the first scenario.
- `abort` at t+10 -> at t+11 `cs_n`=1, `sck` idle, `busy`=0, no `done`. `start` held high during a frame -> no second frame until `busy` falls and `start` is re-sampled.
- `rst_n` low at t+20 mid-frame -> all outputs at reset values at the next edge. A following `start` produces a full, correct frame.
